// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: shared FSM states and constants for the BCD conversion scheduler
package bcd_sched_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
    localparam int DIGIT_W   = 4;
    localparam int SHIFT_CNT = 8;
    localparam int SAT_LIMIT = 99;
endpackage

// File: rtl/bcd_dabble_core.sv
// bcd_dabble_core: iterative 8-bit double-dabble, one bit per clock, hundreds digit discarded
module bcd_dabble_core
    import bcd_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         bin,
    output logic               done,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones
);
    logic [7:0] sr;
    logic [2:0] cnt;
    logic run;
    logic [DIGIT_W-1:0] t3, o3;
    assign t3 = tens >= 4'd5 ? tens + 4'd3 : tens;
    assign o3 = ones >= 4'd5 ? ones + 4'd3 : ones;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            tens <= '0;
            ones <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr   <= bin;
                tens <= '0;
                ones <= '0;
                cnt  <= '0;
                run  <= 1'b1;
            end else if (run) begin
                // the bit shifted out of tens would be the hundreds digit; dropping it yields bin mod 100
                {tens, ones, sr} <= {t3[2:0], o3, sr, 1'b0};
                cnt <= cnt + 3'd1;
                if (cnt == 3'(SHIFT_CNT - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin sharing of one double-dabble BCD converter across NREQ channels
// Define BCD_SAT_EN to clamp inputs above 99 to 9/9 and raise the channel's ovf flag.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int BIN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BIN_W-1:0]   bin_in,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ*DIGIT_W-1:0] tens_out,
    output logic [NREQ*DIGIT_W-1:0] ones_out,
    output logic [NREQ-1:0]         ovf,
    output logic                    busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    state_t state, nxt;
    logic [PW-1:0] ptr, g, pick;
    logic done;
    logic [DIGIT_W-1:0] tens, ones, wt, wo;
    logic [BIN_W-1:0] bin_g;
    assign bin_g = bin_in[BIN_W*g +: BIN_W];
    // scan downward so the first requester at or after ptr wins
    always_comb begin
        pick = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[PW'((int'(ptr) + i) % NREQ)]) pick = PW'((int'(ptr) + i) % NREQ);
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = |req ? LOAD : IDLE;
            LOAD:  nxt = SHIFT;
            SHIFT: nxt = done ? STORE : SHIFT;
            STORE: nxt = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    assign ack  = state == STORE ? NREQ'(1) << g : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            g        <= '0;
            tens_out <= '0;
            ones_out <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && |req) g <= pick;
            if (state == SHIFT && done) begin
                tens_out[DIGIT_W*g +: DIGIT_W] <= wt;
                ones_out[DIGIT_W*g +: DIGIT_W] <= wo;
                ptr <= g == PW'(NREQ - 1) ? '0 : g + 1'b1;
            end
        end
    end
    bcd_dabble_core u_core (
        .clk   (clk),
        .rst   (rst),
        .start (state == LOAD),
        .bin   (bin_g),
        .done  (done),
        .tens  (tens),
        .ones  (ones)
    );
`ifdef BCD_SAT_EN
    logic sat;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat <= 1'b0;
            ovf <= '0;
        end else begin
            if (state == LOAD) sat <= bin_g > BIN_W'(SAT_LIMIT);
            if (state == SHIFT && done) ovf[g] <= sat;
        end
    end
    assign wt = sat ? DIGIT_W'(9) : tens;
    assign wo = sat ? DIGIT_W'(9) : ones;
`else
    assign ovf = '0;
    assign wt  = tens;
    assign wo  = ones;
`endif
endmodule
